// File: rtl/sel_pipe_mux_if.sv
// Handshake bundle for sel_pipe_mux: packed operand inputs, select, flush and the
// registered result with its valid/ready pair.
interface sel_pipe_mux_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
);
    logic [N_IN*WIDTH-1:0] inputs;
    logic [SEL_W-1:0]      select;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      result;
    logic                  sel_err;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err_sticky;

    // upstream/downstream environment side
    modport master (
        output inputs, select, in_valid, flush, out_ready,
        input  in_ready, result, sel_err, out_valid, err_sticky
    );

    // selector stage side
    modport slave (
        input  inputs, select, in_valid, flush, out_ready,
        output in_ready, result, sel_err, out_valid, err_sticky
    );
endinterface

// File: rtl/sel_pipe_mux.sv
// Registered N-way operand selector with valid/ready flow control and a 2-entry
// skid buffer; flags out-of-range selects per beat and stickily.
module sel_pipe_mux #(
    parameter int              WIDTH       = 32,
    parameter int              N_IN        = 4,
    parameter int              SEL_W       = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input logic           clk,
    input logic           reset,
    sel_pipe_mux_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data, skid_data;
    logic             main_err, skid_err;
    logic             sticky_q;

    logic [WIDTH-1:0] cap_data;
    logic             cap_err;
    logic             accept, pop;
    logic             load_main, load_skid, main_from_skid;

    // Capture mux: any select with no matching input falls through to the default.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cap_data = DEFAULT_VAL;
        cap_err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (int'(bus.select) == k) begin
                cap_data = bus.inputs[k*WIDTH +: WIDTH];
                cap_err  = 1'b0;
            end
        end
    end

    assign bus.in_ready  = !reset && (state_q != TWO);
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards everything held; a coinciding pop has already been seen downstream.
        if (bus.flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: both storage entries are reset too, so no stale beat is observable after reset.
        if (reset) begin
            main_data <= '0;
            main_err  <= 1'b0;
            skid_data <= '0;
            skid_err  <= 1'b0;
        end else begin
            if (load_main) begin
                main_data <= cap_data;
                main_err  <= cap_err;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_err  <= skid_err;
            end
            if (load_skid) begin
                skid_data <= cap_data;
                skid_err  <= cap_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else if (accept && cap_err) begin
            sticky_q <= 1'b1;
        end
    end

    assign bus.result     = main_data;
    assign bus.sel_err    = main_err;
    assign bus.err_sticky = sticky_q;

endmodule
